// File: rtl/stream_content_loss.sv
`default_nettype none
// ============================================================================
// Module   : stream_content_loss
// Function : Per-frame streaming loss, sum((content - generated)^2) / 2.
//            Macro CONTENT_LOSS_SAT_EN selects a saturating accumulator.
// Revision : 1.0
// ============================================================================
module stream_content_loss #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LANES    = 4,
  parameter int unsigned N_PIXELS = 1024,
  parameter int unsigned ACC_W    = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] content_pixels,
  input  logic [LANES*DATA_W-1:0] generated_pixels,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        loss_out
);

  localparam int unsigned BEATS = N_PIXELS / LANES;
  localparam int unsigned CNT_W = $clog2(BEATS) + 1;
  localparam int unsigned SQ_W  = 2 * DATA_W;
  localparam int unsigned SUM_W = SQ_W + $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (N_PIXELS % LANES != 0) begin : g_bad_lanes
    $error("N_PIXELS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [ACC_W-1:0]           loss_q, loss_d;
  logic                       v1_q, v1_d;
  logic                       v2_q, v2_d;
  logic                       out_valid_q, out_valid_d;
  logic [LANES-1:0][DATA_W:0] d_q, d_d;
  logic [LANES-1:0][SQ_W-1:0] sq_q, sq_d;
  logic [SUM_W-1:0]           lane_sum;
  logic                       accept;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [SQ_W+1:0] dx;
    logic signed [SQ_W+1:0] prod;
    logic [1:0]             prod_unused;

    // |d| < 2^DATA_W, so the square always fits in SQ_W bits
    assign d_d[k]      = {1'b0, content_pixels[k*DATA_W +: DATA_W]}
                       - {1'b0, generated_pixels[k*DATA_W +: DATA_W]};
    assign dx          = (SQ_W+2)'($signed(d_q[k]));
    assign prod        = dx * dx;
    assign sq_d[k]     = prod[SQ_W-1:0];
    assign prod_unused = prod[SQ_W+1:SQ_W];
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'(sq_q[k]);
    end
  end

`ifdef CONTENT_LOSS_SAT_EN
  localparam int unsigned ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  logic             sat_q, sat_d;
  logic [ADD_W-1:0] acc_sum;
  assign acc_sum = ADD_W'(acc_q) + ADD_W'(lane_sum);
`endif

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready && !clear;
  assign out_valid = out_valid_q;
  assign loss_out  = loss_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    loss_d      = loss_q;
    out_valid_d = out_valid_q;
    v1_d        = accept;
    v2_d        = v1_q;
`ifdef CONTENT_LOSS_SAT_EN
    sat_d       = sat_q;
`endif

    if (v2_q) begin
`ifdef CONTENT_LOSS_SAT_EN
      if (sat_q || (|acc_sum[ADD_W-1:ACC_W])) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
`else
      acc_d = acc_q + ACC_W'(lane_sum);
`endif
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // both stages empty means the last sum already landed in acc_q
        if (!v1_q && !v2_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          loss_d      = acc_q >> 1;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
`ifdef CONTENT_LOSS_SAT_EN
          sat_d       = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      out_valid_d = 1'b0;
`ifdef CONTENT_LOSS_SAT_EN
      sat_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      loss_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      sq_q        <= '0;
`ifdef CONTENT_LOSS_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      loss_q      <= loss_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      sq_q        <= sq_d;
`ifdef CONTENT_LOSS_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_content_loss.sv
`default_nettype none
// Testbench for stream_content_loss: frame table plus hand-written
// backpressure, clear and mid-drain reset sequences.
module tb_stream_content_loss;

  localparam int DATA_W   = 16;
  localparam int LANES    = 4;
  localparam int N_PIXELS = 1024;
  localparam int ACC_W    = 40;
  localparam int BEATS    = N_PIXELS / LANES;

`ifdef CONTENT_LOSS_SAT_EN
  localparam logic [63:0] BIG_EXP = 64'd549755813887;
`else
  localparam logic [63:0] BIG_EXP = 64'd549688705536;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b0;
  logic                    in_ready;
  logic                    out_valid;
  logic [LANES*DATA_W-1:0] content_pixels = '0;
  logic [LANES*DATA_W-1:0] generated_pixels = '0;
  logic [ACC_W-1:0]        loss_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [15:0] c;
    logic [15:0] g;
    int          gap;
    bit          spot;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  stream_content_loss #(
    .DATA_W(DATA_W), .LANES(LANES), .N_PIXELS(N_PIXELS), .ACC_W(ACC_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .content_pixels   (content_pixels),
    .generated_pixels (generated_pixels),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .loss_out         (loss_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(input logic [15:0] c, input logic [15:0] g,
                             input int gap, input bit spot, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      content_pixels   = {LANES{c}};
      generated_pixels = {LANES{g}};
      if (spot && b == 0) begin
        content_pixels[DATA_W-1:0]   = 16'd0;
        generated_pixels[DATA_W-1:0] = 16'd3;
      end
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      if (b != nbeats - 1) repeat (gap) step;
    end
  endtask

  // Called right after the edge that accepted the final beat.
  task automatic collect(input string name, input int hold);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      step;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'd3);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check({name, " loss"}, 64'(loss_out), e);
    if (hold > 0) begin
      content_pixels   = {LANES{16'hFFFF}};
      generated_pixels = '0;
      in_valid         = 1'b1;
      for (int h = 0; h < hold; h++) begin
        step;
        check({name, " stall"}, {22'd0, out_valid, in_ready, loss_out},
              {22'd0, 2'b10, e[ACC_W-1:0]});
      end
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
    check({name, " held"}, 64'(loss_out), e);
  endtask

  initial begin
    int seen;
    vecs[0] = '{16'd100,   16'd90,    0, 1'b0, 64'd51200};
    vecs[1] = '{16'd50,    16'd50,    0, 1'b0, 64'd0};
    vecs[2] = '{16'd65535, 16'd0,     0, 1'b0, BIG_EXP};
    vecs[3] = '{16'd7,     16'd3,     1, 1'b0, 64'd8192};
    vecs[4] = '{16'd20,    16'd20,    0, 1'b1, 64'd4};
    vecs[5] = '{16'd0,     16'd65535, 0, 1'b0, BIG_EXP};
    vecs[6] = '{16'd1000,  16'd1003,  2, 1'b0, 64'd4608};

    // reset state
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset loss_out", 64'(loss_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    check("reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      drive_beats(vecs[i].c, vecs[i].g, vecs[i].gap, vecs[i].spot, BEATS);
      exp_q.push_back(vecs[i].exp);
      collect($sformatf("vec%0d", i), 0);
    end

    // backpressure: result held for 10 cycles, input beats ignored
    drive_beats(16'd100, 16'd90, 0, 1'b0, BEATS);
    exp_q.push_back(64'd51200);
    collect("stall", 10);
    drive_beats(16'd7, 16'd3, 0, 1'b0, BEATS);
    exp_q.push_back(64'd8192);
    collect("after_stall", 0);

    // clear mid-frame drops partial sums and the coincident beat
    drive_beats(16'd65535, 16'd0, 0, 1'b0, 100);
    clear            = 1'b1;
    in_valid         = 1'b1;
    content_pixels   = {LANES{16'hFFFF}};
    generated_pixels = '0;
    step;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear state", {62'd0, out_valid, in_ready}, 64'd1);
    drive_beats(16'd100, 16'd90, 0, 1'b0, BEATS);
    exp_q.push_back(64'd51200);
    collect("after_clear", 0);

    // reset while draining: no result for that frame
    drive_beats(16'd100, 16'd90, 0, 1'b0, BEATS);
    step;
    #2;
    rst_n = 1'b0;
    #1;
    check("drain reset out_valid", 64'(out_valid), 64'd0);
    check("drain reset loss_out", 64'(loss_out), 64'd0);
    check("drain reset in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step;
      if (out_valid) seen++;
    end
    check("drain reset no result", 64'(seen), 64'd0);
    drive_beats(16'd7, 16'd3, 0, 1'b0, BEATS);
    exp_q.push_back(64'd8192);
    collect("after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_content_loss.md
STREAM_CONTENT_LOSS -- requirements
Module: stream_content_loss

Interface
REQ-001 SHALL have parameter DATA_W, default 16, unsigned pixel width.
REQ-002 SHALL have parameter LANES, default 4, pixel pairs accepted per beat.
REQ-003 SHALL have parameter N_PIXELS, default 1024, pixels per frame; N_PIXELS % LANES == 0 is required (elaboration error otherwise).
REQ-004 SHALL have parameter ACC_W, default 40, accumulator and loss width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clear  input  1  synchronous frame abort.
REQ-008 in_valid  input  1  beat valid.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 content_pixels  input  LANES*DATA_W  lane k in bits [k*DATA_W +: DATA_W].
REQ-011 generated_pixels  input  LANES*DATA_W  same packing.
REQ-012 out_valid  output  1  loss_out valid.
REQ-013 out_ready  input  1  consumer accepts loss_out.
REQ-014 loss_out  output  ACC_W  frame loss = sum of squared differences / 2.

Function
REQ-015 Per lane, SHALL compute d = content - generated as signed DATA_W+1 bits and sq = d*d as unsigned 2*DATA_W bits (exact).
REQ-016 SHALL be a 3-stage pipeline: edge of acceptance registers d; next edge registers sq; next edge adds the LANES-wide sum of sq into the accumulator.
REQ-017 SHALL count accepted beats; beat N_PIXELS/LANES is the final beat of the frame; there is no explicit last signal.
REQ-018 FSM states: ACCUM (in_ready=1), DRAIN (in_ready=0, pipeline emptying), DONE (in_ready=0, out_valid=1).
REQ-019 ACCUM->DRAIN on the edge accepting the final beat; DRAIN->DONE after 2 further edges, loss_out registered = acc >> 1 (floor) and out_valid=1 on the 3rd edge after final-beat acceptance.
REQ-020 DONE->ACCUM on the edge where out_valid && out_ready; same edge zeroes accumulator and beat counter; loss_out holds its value until the next frame completes.
REQ-021 loss_out and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-022 Pipeline stages SHALL accept beats back-to-back at one beat per cycle with no bubbles in ACCUM; idle cycles (in_valid=0) insert no data.
REQ-023 Accumulator arithmetic SHALL be modulo 2^ACC_W unless CONTENT_LOSS_SAT_EN is defined.
REQ-024 clear=1 SHALL, on that edge, zero accumulator, beat counter and pipeline valids, drop out_valid, enter ACCUM; a beat presented in the same cycle is discarded; clear has priority over all other events.
REQ-025 Frame of all-equal pixels SHALL yield loss_out = 0.

Reset
REQ-026 rst_n low SHALL immediately force: state ACCUM, accumulator 0, beat counter 0, pipeline valids 0, out_valid 0, loss_out 0; in_ready = 1 after release.
REQ-027 Reset mid-frame or in DONE SHALL discard all partial results; first beat after release starts a new frame.

Configuration
REQ-028 Macro CONTENT_LOSS_SAT_EN: when defined, accumulator add SHALL saturate at 2^ACC_W-1 and a sticky internal flag keeps it there until frame restart; when undefined, add wraps modulo 2^ACC_W.

Verification
REQ-029 Defaults, 256 beats, content=100, generated=90 every lane -> loss_out = 1024*100/2 = 51200, out_valid 3 edges after beat 256.
REQ-030 Defaults, one lane pair 0/3 in beat 0, all else equal -> loss_out = 4 (9>>1 floor).
REQ-031 Defaults, content=65535, generated=0 everywhere: sum = 1024*4294836225; without macro -> loss_out = (sum mod 2^40)>>1; with CONTENT_LOSS_SAT_EN -> loss_out = (2^40-1)>>1.
REQ-032 Complete frame, out_ready held 0 for 10 cycles -> loss_out stable, in_ready=0, in_valid ignored; out_ready=1 -> next cycle ACCUM, in_ready=1.
REQ-033 clear asserted after 100 beats, then full frame of 100/90 -> loss_out = 51200 (no residue).
REQ-034 rst_n pulsed low mid-DRAIN -> out_valid never rises for that frame; outputs 0 asynchronously; subsequent frame correct.
